// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared op-codes and widths for the MIPS ALU bit slices.
//                OP_* values drive the slice result select; W is the operand
//                width and MW the length of the MUL column carry vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_SLT = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    localparam int W  = 32;
    localparam int MW = 31;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_full_adder
//  Description : 1-bit full adder shared by the add/sub path and the MUL
//                column chain.
//  Ports       : a, b, ci  - addend bits and carry-in
//                s         - sum bit  (a ^ b ^ ci)
//                co        - carry-out (majority of a, b, ci)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : alu_full_adder
`default_nettype wire

// File: rtl/alu_bit_slice.sv
`default_nettype none
// ============================================================================
//  Module      : alu_bit_slice
//  Description : One bit position of the 32-bit MIPS ALU. Computes ADD, SUB,
//                XOR, SLT and one anti-diagonal column of the 32x32 multiply
//                array. The selected result is registered; add/sub and MUL
//                carries are combinational so slices chain within one cycle.
//  Ports       : clk      - rising-edge clock
//                rst_n    - asynchronous active-low reset (clears out)
//                a, b     - operand bits for this slice
//                cin      - add/sub carry-in from the lower slice
//                cntrl    - op select (0 ADD,1 SUB,2 XOR,3 SLT,4 MUL,5-7 zero)
//                a32, b32 - full operands for the MUL column
//                c_in_m   - MUL column carries from the lower slice
//                out      - registered result bit
//                cout     - add/sub carry-out
//                c_out_m  - MUL column carries to the upper slice
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a,
    input  logic          b,
    input  logic          cin,
    input  logic [2:0]    cntrl,
    input  logic [W-1:0]  a32,
    input  logic [W-1:0]  b32,
    input  logic [MW-1:0] c_in_m,
    output logic          out,
    output logic          cout,
    output logic [MW-1:0] c_out_m
);

    logic          w_bin;
    logic          w_sum;
    logic          w_xr;
    logic          w_sel;
    logic [W-1:0]  w_p;
    logic [MW-1:0] w_s;
    logic          r_out;

    // ------------------------------------------------------------------------
    // Add/sub: B is inverted for SUB and SLT (cntrl[0]); the +1 of two's
    // complement comes in through the slice-0 carry-in.
    // ------------------------------------------------------------------------
    assign w_bin = b ^ cntrl[0];

    alu_full_adder u_addsub (
        .a  (a),
        .b  (w_bin),
        .ci (cin),
        .s  (w_sum),
        .co (cout)
    );

    // XOR deliberately uses raw b, not the inverted operand.
    assign w_xr = a ^ b;

    // ------------------------------------------------------------------------
    // MUL column: partial products along the anti-diagonal k + (31-k) = 31.
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < W; k++) begin : g_pp
            assign w_p[k] = a32[k] & b32[W-1-k];
        end

        for (genvar i = 0; i < MW; i++) begin : g_mul_chain
            if (i == 0) begin : g_stage0
                // First stage seeds the chain with both p[0] and p[1].
                alu_full_adder u_fa (
                    .a  (w_p[0]),
                    .b  (w_p[1]),
                    .ci (c_in_m[0]),
                    .s  (w_s[0]),
                    .co (c_out_m[0])
                );
            end else begin : g_stage_n
                alu_full_adder u_fa (
                    .a  (w_s[i-1]),
                    .b  (w_p[i+1]),
                    .ci (c_in_m[i]),
                    .s  (w_s[i]),
                    .co (c_out_m[i])
                );
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Result select. SLT returns the raw difference bit; the sign fixup is
    // done by the top-level ALU. Reserved codes yield 0.
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel = 1'b0;
        case (cntrl)
            OP_ADD:  w_sel = w_sum;
            OP_SUB:  w_sel = w_sum;
            OP_XOR:  w_sel = w_xr;
            OP_SLT:  w_sel = w_sum;
            OP_MUL:  w_sel = w_s[MW-1];
            default: w_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_sel;
        end
    end

    assign out = r_out;

endmodule : alu_bit_slice
`default_nettype wire

// File: tb/tb_alu_bit_slice.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_bit_slice
//  Description : Self-checking bench for alu_bit_slice. Table of directed
//                vectors plus hand-written reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_bit_slice;

    logic        clk;
    logic        rst_n;
    logic        a;
    logic        b;
    logic        cin;
    logic [2:0]  cntrl;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [30:0] c_in_m;
    logic        out;
    logic        cout;
    logic [30:0] c_out_m;

    int n_tests;
    int n_fail;

    alu_bit_slice dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .cntrl   (cntrl),
        .a32     (a32),
        .b32     (b32),
        .c_in_m  (c_in_m),
        .out     (out),
        .cout    (cout),
        .c_out_m (c_out_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cntrl;
        logic        a;
        logic        b;
        logic        cin;
        logic [31:0] a32;
        logic [31:0] b32;
        logic [30:0] cm;
        logic        exp_out;
        logic        exp_cout;
        logic [30:0] exp_cm;
        logic        chk_cm;
    } vec_t;

    vec_t vecs[$];

    // Reference of the MUL column: returns {carries[30:0], result}.
    function automatic logic [31:0] mul_ref(input logic [31:0] x, input logic [31:0] y,
                                            input logic [30:0] ci);
        logic [31:0] pp;
        logic        acc;
        logic [1:0]  t;
        logic [30:0] co;
        for (int k = 0; k < 32; k++) pp[k] = x[k] & y[31-k];
        acc = pp[0];
        for (int i = 0; i < 31; i++) begin
            t     = 2'(acc) + 2'(pp[i+1]) + 2'(ci[i]);
            acc   = t[0];
            co[i] = t[1];
        end
        return {co, acc};
    endfunction

    task automatic check1(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic check31(input string name, input logic [30:0] act, input logic [30:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic [2:0] c, input logic ia, input logic ib, input logic ic,
                           input logic [31:0] x, input logic [31:0] y, input logic [30:0] m,
                           input logic eo, input logic ec, input logic [30:0] em, input logic chk);
        vec_t v;
        v.cntrl = c;  v.a = ia;  v.b = ib;  v.cin = ic;
        v.a32 = x;    v.b32 = y; v.cm = m;
        v.exp_out = eo; v.exp_cout = ec; v.exp_cm = em; v.chk_cm = chk;
        vecs.push_back(v);
    endtask

    logic [31:0] r_ref;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // ---------------- vector table ----------------
        // SUB, b=1: cout 0/0/0/1, out 1/0/1/0
        add_vec(3'd1, 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        add_vec(3'd1, 1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        add_vec(3'd1, 1'b0, 1'b1, 1'b1, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        add_vec(3'd1, 1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
        // ADD 1+1+1
        add_vec(3'd0, 1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b1, 1'b1, '0, 1'b0);
        add_vec(3'd0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        // XOR uses raw b
        add_vec(3'd2, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        add_vec(3'd2, 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
        add_vec(3'd2, 1'b0, 1'b1, 1'b1, '0, '0, '0, 1'b1, 1'b1, '0, 1'b0);
        // SLT: inverted b
        add_vec(3'd3, 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        add_vec(3'd3, 1'b0, 1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
        // MUL: single partial product p[0]
        add_vec(3'd4, 1'b0, 1'b0, 1'b0, 32'h1, 32'h8000_0000, 31'h0,
                1'b1, 1'b0, 31'h0, 1'b1);
        add_vec(3'd4, 1'b0, 1'b0, 1'b0, 32'h1, 32'h8000_0000, 31'h1,
                1'b0, 1'b0, 31'h1, 1'b1);
        // MUL: all ones -> 32 ones in the column, carries on even stages
        add_vec(3'd4, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 31'h0,
                1'b0, 1'b0, 31'h5555_5555, 1'b1);
        // MUL: mixed operands against the reference model
        r_ref = mul_ref(32'hA5A5_1234, 32'h0F0F_F00F, 31'h1234_5678);
        add_vec(3'd4, 1'b1, 1'b1, 1'b0, 32'hA5A5_1234, 32'h0F0F_F00F, 31'h1234_5678,
                r_ref[0], 1'b1, r_ref[31:1], 1'b1);
        r_ref = mul_ref(32'hFFFF_FFFF, 32'hFFFF_FFFF, 31'h7FFF_FFFF);
        add_vec(3'd4, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 31'h7FFF_FFFF,
                r_ref[0], 1'b0, r_ref[31:1], 1'b1);
        // Reserved codes: out 0, cout still a+(b^cntrl[0])+cin
        add_vec(3'd5, 1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
        add_vec(3'd6, 1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
        add_vec(3'd7, 1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
        add_vec(3'd5, 1'b0, 1'b1, 1'b1, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);

        // ---------------- reset with arbitrary inputs ----------------
        rst_n  = 1'b0;
        a      = 1'b1;
        b      = 1'b0;
        cin    = 1'b0;
        cntrl  = 3'd0;
        a32    = 32'h1234_5678;
        b32    = 32'h9ABC_DEF0;
        c_in_m = 31'h0;
        #1;
        check1("reset_out", out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("post_reset_load", out, 1'b1);

        // ---------------- asynchronous reset mid-operation ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check1("async_reset_clear", out, 1'b0);
        @(posedge clk);
        #1;
        check1("reset_hold", out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("reset_release_load", out, 1'b1);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            cntrl  = vecs[i].cntrl;
            a      = vecs[i].a;
            b      = vecs[i].b;
            cin    = vecs[i].cin;
            a32    = vecs[i].a32;
            b32    = vecs[i].b32;
            c_in_m = vecs[i].cm;
            #1;
            check1($sformatf("vec%0d_cout", i), cout, vecs[i].exp_cout);
            if (vecs[i].chk_cm)
                check31($sformatf("vec%0d_c_out_m", i), c_out_m, vecs[i].exp_cm);
            @(posedge clk);
            #1;
            check1($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
        end

        // ---------------- out holds one-cycle latency ----------------
        @(negedge clk);
        cntrl = 3'd2; a = 1'b1; b = 1'b0; cin = 1'b0;
        #1;
        check1("latency_before_edge", out, 1'b0);
        @(posedge clk);
        #1;
        check1("latency_after_edge", out, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_bit_slice
`default_nettype wire
